// File: rtl/mipi_rx_frame_ctrl.sv
// mipi_rx_frame_ctrl: sequences the CSI-2 receive path, tracks frame/line structure and gates
// reference-type video payload toward the byte-to-pixel converter.
module mipi_rx_frame_ctrl #(
  parameter int NUM_RX_LANE = 2,
  parameter int RX_GEAR     = 8,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CNT_W       = 16
) (
  input  logic             byte_clk,
  input  logic             byte_clk_rst_n,
  input  logic             enable_i,
  input  logic [7:0]       capture_cnt_i,
  input  logic [5:0]       ref_dt_i,
  input  logic             err_clr_i,
  input  logic             sp_en_i,
  input  logic             lp_av_en_i,
  input  logic             payload_en_i,
  input  logic [5:0]       dt_i,
  input  logic [15:0]      wc_i,
  output logic             tx_rdy_o,
  output logic             payload_en_o,
  output logic             frame_active_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [CNT_W-1:0] last_line_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             err_wc_o,
  output logic             err_seq_o,
  output logic             err_timeout_o,
  output logic             busy_o
);
  localparam int BPC = NUM_RX_LANE * RX_GEAR / 8;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  // RESTART opens a new frame right after an FS that arrived inside a frame closed it
  typedef enum logic [2:0] {IDLE, WAIT_FS, FRAME, LINE, RESTART, DONE} state_t;
  state_t state, state_n;
  logic [7:0]    rem;
  logic [15:0]   wc_q;
  logic [16:0]   beats, exp_beats;
  logic [TW-1:0] tmo;
  logic both, is_fs, is_fe, is_ref, active, quiet, tmo_hit;
  logic do_start, do_end, line_close, seq_err;
  assign both      = sp_en_i & lp_av_en_i;
  assign is_fs     = sp_en_i & ~lp_av_en_i & (dt_i == 6'h00);
  assign is_fe     = sp_en_i & ~lp_av_en_i & (dt_i == 6'h01);
  assign is_ref    = lp_av_en_i & ~sp_en_i & (dt_i == ref_dt_i);
  assign active    = (state == FRAME) || (state == LINE);
  assign quiet     = ~(sp_en_i | lp_av_en_i | payload_en_i);
  assign tmo_hit   = active && quiet && (tmo == TW'(TIMEOUT_CYC - 1));
  assign exp_beats = 17'(({1'b0, wc_q} + 17'(BPC - 1)) / 17'(BPC));
  assign tx_rdy_o       = (state == WAIT_FS) || (state == RESTART);
  assign frame_active_o = active;
  assign payload_en_o   = (state == LINE) & payload_en_i;
  assign busy_o         = state != IDLE;
  always_comb begin
    state_n    = state;
    do_start   = 1'b0;
    do_end     = 1'b0;
    line_close = 1'b0;
    seq_err    = both;
    unique case (state)
      IDLE:    state_n = enable_i ? WAIT_FS : IDLE;
      WAIT_FS: begin
        seq_err  = both | is_fe;
        do_start = enable_i & is_fs;
        state_n  = !enable_i ? IDLE : is_fs ? FRAME : WAIT_FS;
      end
      RESTART: begin
        do_start = 1'b1;
        state_n  = FRAME;
      end
      FRAME: begin
        if (tmo_hit) state_n = enable_i ? WAIT_FS : IDLE;
        else if (is_fe || is_fs) begin
          do_end  = 1'b1;
          seq_err = both | is_fs;
          state_n = (rem == 8'd1) ? DONE : !enable_i ? IDLE : is_fs ? RESTART : WAIT_FS;
        end else if (is_ref) state_n = LINE;
      end
      LINE: begin
        if (tmo_hit) state_n = enable_i ? WAIT_FS : IDLE;
        else if (!payload_en_i && beats != 17'd0) begin
          line_close = 1'b1;
          state_n    = FRAME;
        end
      end
      DONE:    state_n = enable_i ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge byte_clk or negedge byte_clk_rst_n)
    if (!byte_clk_rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge byte_clk or negedge byte_clk_rst_n) begin
    if (!byte_clk_rst_n) begin
      rem             <= '0;
      wc_q            <= '0;
      beats           <= '0;
      tmo             <= '0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_cnt_o      <= '0;
      last_line_cnt_o <= '0;
      frame_cnt_o     <= '0;
      err_wc_o        <= 1'b0;
      err_seq_o       <= 1'b0;
      err_timeout_o   <= 1'b0;
    end else begin
      frame_start_o <= do_start;
      frame_end_o   <= do_end | tmo_hit;
      tmo           <= (active && quiet && !tmo_hit) ? tmo + TW'(1) : '0;
      if (state == IDLE && enable_i) rem <= capture_cnt_i;
      else if (do_end && rem != 8'd0) rem <= rem - 8'd1;
      if (state == FRAME && state_n == LINE) begin
        wc_q  <= wc_i;
        beats <= '0;
      end else if (state == LINE && payload_en_i && beats != '1) beats <= beats + 17'd1;
      if (do_start) line_cnt_o <= '0;
      else if (line_close && line_cnt_o != '1) line_cnt_o <= line_cnt_o + CNT_W'(1);
      if (do_end || tmo_hit) last_line_cnt_o <= line_cnt_o;
      if (do_end) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      err_wc_o      <= (err_wc_o & ~err_clr_i) | (line_close && beats != exp_beats);
      err_seq_o     <= (err_seq_o & ~err_clr_i) | seq_err;
      err_timeout_o <= (err_timeout_o & ~err_clr_i) | tmo_hit;
    end
  end
endmodule

// File: tb/tb_mipi_rx_frame_ctrl.sv
// tb_mipi_rx_frame_ctrl: directed and randomized packet streams checked against a packet-level
// model of frame structure, payload gating and word-count rules.
module tb_mipi_rx_frame_ctrl;
  localparam int TMO = 64;
  localparam int BPC = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic [7:0]  capture_cnt_i = '0;
  logic [5:0]  ref_dt_i = 6'h2B;
  logic        err_clr_i = 1'b0;
  logic        sp_en_i = 1'b0;
  logic        lp_av_en_i = 1'b0;
  logic        payload_en_i = 1'b0;
  logic [5:0]  dt_i = '0;
  logic [15:0] wc_i = '0;
  logic        tx_rdy_o, payload_en_o, frame_active_o, frame_start_o, frame_end_o;
  logic [15:0] line_cnt_o, last_line_cnt_o, frame_cnt_o;
  logic        err_wc_o, err_seq_o, err_timeout_o, busy_o;
  int vectors = 0, miscompares = 0;
  int cyc = 0, pe_n = 0, fs_n = 0, fe_n = 0, fs_cyc = 0, fe_cyc = 0;

  mipi_rx_frame_ctrl #(.NUM_RX_LANE(2), .RX_GEAR(8), .TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .byte_clk(clk), .byte_clk_rst_n(rst_n), .enable_i(enable_i), .capture_cnt_i(capture_cnt_i),
    .ref_dt_i(ref_dt_i), .err_clr_i(err_clr_i), .sp_en_i(sp_en_i), .lp_av_en_i(lp_av_en_i),
    .payload_en_i(payload_en_i), .dt_i(dt_i), .wc_i(wc_i), .tx_rdy_o(tx_rdy_o),
    .payload_en_o(payload_en_o), .frame_active_o(frame_active_o), .frame_start_o(frame_start_o),
    .frame_end_o(frame_end_o), .line_cnt_o(line_cnt_o), .last_line_cnt_o(last_line_cnt_o),
    .frame_cnt_o(frame_cnt_o), .err_wc_o(err_wc_o), .err_seq_o(err_seq_o),
    .err_timeout_o(err_timeout_o), .busy_o(busy_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (payload_en_o) pe_n++;
    if (frame_start_o) begin fs_n++; fs_cyc = cyc; end
    if (frame_end_o) begin fe_n++; fe_cyc = cyc; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic short_pkt(input logic [5:0] dt);
    sp_en_i = 1'b1; dt_i = dt; step(); sp_en_i = 1'b0;
  endtask

  task automatic long_pkt(input logic [5:0] dt, input logic [15:0] wc, input int nb, input bit clr);
    lp_av_en_i = 1'b1; dt_i = dt; wc_i = wc; step(); lp_av_en_i = 1'b0;
    payload_en_i = 1'b1;
    repeat (nb) step();
    payload_en_i = 1'b0; err_clr_i = clr; step(); err_clr_i = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
  endtask

  initial begin
    int pe0, fe0, fs0, fc0, hit, lines, pes, bad, need, nb;
    logic [5:0] dt;
    logic [15:0] wc;
    #3;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_outs", {tx_rdy_o, payload_en_o, frame_active_o, frame_start_o, frame_end_o,
                     err_wc_o, err_seq_o, err_timeout_o}, 0);
    chk("rst_cnts", {line_cnt_o, frame_cnt_o} | 32'(last_line_cnt_o), 0);
    #10 rst_n = 1'b1;
    step();
    // plain frame of four correctly sized lines
    enable_i = 1'b1; step();
    chk("t1_tx_rdy", 32'(tx_rdy_o), 1);
    pe0 = pe_n; fs0 = fs_n; fe0 = fe_n;
    short_pkt(6'h00);
    chk("t1_active", 32'(frame_active_o), 1);
    repeat (4) long_pkt(6'h2B, 16'd10, 5, 1'b0);
    chk("t1_line_cnt", 32'(line_cnt_o), 4);
    short_pkt(6'h01);
    step();
    chk("t1_last_line", 32'(last_line_cnt_o), 4);
    chk("t1_frame_cnt", 32'(frame_cnt_o), 1);
    chk("t1_payload_cycles", 32'(pe_n - pe0), 20);
    chk("t1_fs_fe", 32'({fs_n - fs0, fe_n - fe0}), {32'd1, 32'd1} >> 0 == 0 ? 0 : 32'(64'h1_0000_0001));
    chk("t1_errs", {err_wc_o, err_seq_o, err_timeout_o}, 0);
    chk("t1_state_wait", 32'(tx_rdy_o), 1);
    // word-count checking, clear, and error-beats-clear
    short_pkt(6'h00);
    long_pkt(6'h2B, 16'd10, 4, 1'b0);
    chk("t2_err_wc_set", 32'(err_wc_o), 1);
    long_pkt(6'h2B, 16'd10, 3, 1'b1);
    chk("t2_err_wins_clr", 32'(err_wc_o), 1);
    clear_errs();
    chk("t2_err_cleared", 32'(err_wc_o), 0);
    long_pkt(6'h2B, 16'd9, 5, 1'b0);
    chk("t2_odd_wc_ok", 32'(err_wc_o), 0);
    short_pkt(6'h01);
    // two-frame capture then stop
    enable_i = 1'b0; step();
    chk("t3_idle", 32'(busy_o), 0);
    capture_cnt_i = 8'd2; enable_i = 1'b1; step();
    fc0 = frame_cnt_o;
    repeat (2) begin short_pkt(6'h00); long_pkt(6'h2B, 16'd10, 5, 1'b0); short_pkt(6'h01); end
    chk("t3_done_tx_rdy", 32'(tx_rdy_o), 0);
    chk("t3_done_busy", 32'(busy_o), 1);
    pe0 = pe_n; fs0 = fs_n;
    short_pkt(6'h00); long_pkt(6'h2B, 16'd10, 5, 1'b0); short_pkt(6'h01);
    step();
    chk("t3_frame_cnt", 32'(frame_cnt_o), 32'(fc0 + 2));
    chk("t3_no_payload", 32'(pe_n - pe0), 0);
    chk("t3_no_start", 32'(fs_n - fs0), 0);
    capture_cnt_i = 8'd0; enable_i = 1'b0; step();
    chk("t3_back_idle", 32'(busy_o), 0);
    // sequence errors
    enable_i = 1'b1; step();
    short_pkt(6'h01);
    chk("t4_fe_in_wait", 32'(err_seq_o), 1);
    chk("t4_still_wait", 32'(tx_rdy_o), 1);
    clear_errs();
    short_pkt(6'h00);
    long_pkt(6'h2B, 16'd4, 2, 1'b0);
    fc0 = frame_cnt_o;
    short_pkt(6'h00);
    step(); step();
    chk("t4_fs_in_frame_err", 32'(err_seq_o), 1);
    chk("t4_end_then_start", 32'(fs_cyc - fe_cyc), 1);
    chk("t4_reopened", 32'(frame_active_o), 1);
    chk("t4_frame_cnt", 32'(frame_cnt_o), 32'(fc0 + 1));
    clear_errs();
    fe0 = fe_n;
    sp_en_i = 1'b1; lp_av_en_i = 1'b1; dt_i = 6'h01; step(); sp_en_i = 1'b0; lp_av_en_i = 1'b0;
    step();
    chk("t4_sp_lp_err", 32'(err_seq_o), 1);
    chk("t4_sp_lp_ignored", 32'({frame_active_o, 7'(fe_n - fe0)}), 32'h80);
    short_pkt(6'h01);
    clear_errs();
    // timeout after one line of silence
    short_pkt(6'h00);
    long_pkt(6'h2B, 16'd4, 2, 1'b0);
    fc0 = frame_cnt_o;
    hit = 0;
    for (int i = 2; i <= TMO + 16 && hit == 0; i++) begin
      step();
      if (frame_end_o) hit = i;
    end
    chk("t5_timeout_cycle", 32'(hit), TMO);
    chk("t5_err_timeout", 32'(err_timeout_o), 1);
    chk("t5_frame_cnt_same", 32'(frame_cnt_o), 32'(fc0));
    chk("t5_last_line", 32'(last_line_cnt_o), 1);
    chk("t5_wait_fs", 32'({tx_rdy_o, frame_active_o}), 2);
    clear_errs();
    // foreign data type and reset mid-line
    short_pkt(6'h00);
    pe0 = pe_n;
    long_pkt(6'h12, 16'd6, 3, 1'b0);
    chk("t6_foreign_gated", 32'(pe_n - pe0), 0);
    chk("t6_foreign_no_line", 32'(line_cnt_o), 0);
    lp_av_en_i = 1'b1; dt_i = 6'h2B; wc_i = 16'd10; step(); lp_av_en_i = 1'b0;
    payload_en_i = 1'b1; step(); step();
    chk("t6_in_line", 32'(payload_en_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {tx_rdy_o, payload_en_o, frame_active_o, frame_start_o, frame_end_o,
                        err_wc_o, err_seq_o, err_timeout_o, busy_o}, 0);
    chk("t6_rst_cnts", {line_cnt_o, frame_cnt_o} | 32'(last_line_cnt_o), 0);
    payload_en_i = 1'b0; fe0 = fe_n;
    step(); step();
    chk("t6_no_frame_end", 32'(fe_n - fe0), 0);
    rst_n = 1'b1; step();
    // randomized frames against a packet-level model
    step();
    for (int f = 1; f <= 8; f++) begin
      lines = 0; pes = 0; bad = 0;
      pe0 = pe_n;
      short_pkt(6'h00);
      repeat ($urandom_range(1, 5)) begin
        dt = ($urandom_range(0, 3) != 0) ? 6'h2B : 6'($urandom_range(16'h10, 16'h2A));
        wc = 16'($urandom_range(1, 16));
        need = (int'(wc) + BPC - 1) / BPC;
        nb = need;
        if ($urandom_range(0, 2) == 0) nb = (need > 1 && $urandom_range(0, 1) == 0) ? need - 1 : need + 1;
        long_pkt(dt, wc, nb, 1'b0);
        if (dt == 6'h2B) begin
          lines++; pes += nb;
          if (nb != need) bad = 1;
        end
        repeat ($urandom_range(0, 3)) step();
        if ($urandom_range(0, 3) == 0) short_pkt(6'($urandom_range(2, 15)));
      end
      chk("rnd_line_cnt", 32'(line_cnt_o), 32'(lines));
      short_pkt(6'h01);
      step();
      chk("rnd_last_line", 32'(last_line_cnt_o), 32'(lines));
      chk("rnd_frame_cnt", 32'(frame_cnt_o), 32'(f));
      chk("rnd_payload", 32'(pe_n - pe0), 32'(pes));
      chk("rnd_err_wc", 32'(err_wc_o), 32'(bad));
      chk("rnd_err_seq", 32'({err_seq_o, err_timeout_o}), 0);
      clear_errs();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
